// File: rtl/fifo_ctrl_unit_pkg.sv
// Shared definitions for the FIFO control register block: FCR bit map,
// trigger-level codes and the character-timeout state encoding.
package fifo_ctrl_unit_pkg;

  localparam int FCR_FIFOEN  = 0;
  localparam int FCR_RXCLR   = 1;
  localparam int FCR_TXCLR   = 2;
  localparam int FCR_DMAMODE = 3;
  localparam int FCR_TRIG_LO = 6;
  localparam int FCR_TRIG_HI = 7;

  localparam logic [1:0] TRIG_ONE       = 2'b00;
  localparam logic [1:0] TRIG_QUARTER   = 2'b01;
  localparam logic [1:0] TRIG_HALF      = 2'b10;
  localparam logic [1:0] TRIG_NEAR_FULL = 2'b11;

  // Character times without FIFO activity before the timeout fires.
  localparam logic [2:0] TICK_LIMIT = 3'd4;

  typedef enum logic [1:0] {
    TO_IDLE    = 2'd0,
    TO_ARMED   = 2'd1,
    TO_EXPIRED = 2'd2
  } timeout_state_e;

  function automatic int unsigned trig_threshold(input logic [1:0] code,
                                                 input int unsigned depth);
    case (code)
      TRIG_ONE:     return 1;
      TRIG_QUARTER: return depth / 4;
      TRIG_HALF:    return depth / 2;
      default:      return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/rx_timeout_fsm.sv
// RX character-timeout tracker: arms while the FIFO holds data, counts idle
// character times and flags a timeout until the FIFO is touched again.
module rx_timeout_fsm
  import fifo_ctrl_unit_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic fifoen_i,
  input  logic rxclr_i,
  input  logic rx_nonempty_i,
  input  logic rx_push_i,
  input  logic rx_pop_i,
  input  logic char_tick_i,
  output logic rx_timeout_o
);

  timeout_state_e state_q, state_d;
  logic [2:0]     tick_cnt_q, tick_cnt_d;
  logic           timeout_q, timeout_d;
  logic           activity;

  assign activity = rx_push_i || rx_pop_i;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= TO_IDLE;
      tick_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    if (!rx_nonempty_i || !fifoen_i || rxclr_i) begin
      state_d    = TO_IDLE;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        TO_IDLE: begin
          state_d    = TO_ARMED;
          tick_cnt_d = '0;
        end
        TO_ARMED: begin
          // FIFO activity restarts the idle interval even on a tick cycle.
          if (activity) begin
            tick_cnt_d = '0;
          end else if (char_tick_i) begin
            tick_cnt_d = tick_cnt_q + 3'd1;
            if (tick_cnt_d == TICK_LIMIT) state_d = TO_EXPIRED;
          end
        end
        TO_EXPIRED: begin
          if (activity) begin
            state_d    = TO_ARMED;
            tick_cnt_d = '0;
          end
        end
        default: begin
          state_d    = TO_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    timeout_d = (state_d == TO_EXPIRED);
  end

  assign rx_timeout_o = timeout_q;

endmodule

// File: rtl/fifo_ctrl_unit.sv
// FIFO control register (FCR) decode with self-clearing FIFO clear pulses,
// RX trigger-level threshold/flag and the RX character-timeout tracker.
module fifo_ctrl_unit
  import fifo_ctrl_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    FCR_ADDR = ADDR_W'(8'h08),
  parameter int unsigned          DEPTH    = 16,
  parameter int unsigned          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  input  logic [CNT_W-1:0]  rx_count,
  input  logic              rx_push,
  input  logic              rx_pop,
  input  logic              char_tick,
  output logic              FIFOEN,
  output logic              RXCLR,
  output logic              TXCLR,
  output logic              DMAMODE,
  output logic [1:0]        RXFIFTL,
  output logic [CNT_W-1:0]  rx_threshold,
  output logic              rx_trig,
  output logic              rx_timeout
);

  logic       fifoen_q, fifoen_d;
  logic       rxclr_q, rxclr_d;
  logic       txclr_q, txclr_d;
  logic       dmamode_q, dmamode_d;
  logic [1:0] rxfiftl_q, rxfiftl_d;
  logic       rx_trig_q, rx_trig_d;
  logic       fcr_wr;
  logic       unused_fcr_bits;

  assign fcr_wr          = wr_en && (address == FCR_ADDR);
  assign unused_fcr_bits = ^data_in[5:4];

  // NOTE: every comb output gets a default first, so no latch is inferred.
  always_comb begin
    fifoen_d  = fifoen_q;
    dmamode_d = dmamode_q;
    rxfiftl_d = rxfiftl_q;
    rxclr_d   = 1'b0;
    txclr_d   = 1'b0;
    if (fcr_wr) begin
      fifoen_d = data_in[FCR_FIFOEN];
      if (data_in[FCR_FIFOEN]) begin
        dmamode_d = data_in[FCR_DMAMODE];
        rxfiftl_d = data_in[FCR_TRIG_HI:FCR_TRIG_LO];
      end
      // Toggling the enable flushes both FIFOs just like an explicit clear.
      rxclr_d = data_in[FCR_RXCLR] || (data_in[FCR_FIFOEN] != fifoen_q);
      txclr_d = data_in[FCR_TXCLR] || (data_in[FCR_FIFOEN] != fifoen_q);
    end
  end

  assign rx_threshold = CNT_W'(trig_threshold(rxfiftl_q, DEPTH));
  assign rx_trig_d    = fifoen_q && (rx_count >= rx_threshold) && !rxclr_d;

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      fifoen_q  <= 1'b0;
      rxclr_q   <= 1'b0;
      txclr_q   <= 1'b0;
      dmamode_q <= 1'b0;
      rxfiftl_q <= TRIG_ONE;
      rx_trig_q <= 1'b0;
    end else begin
      fifoen_q  <= fifoen_d;
      rxclr_q   <= rxclr_d;
      txclr_q   <= txclr_d;
      dmamode_q <= dmamode_d;
      rxfiftl_q <= rxfiftl_d;
      rx_trig_q <= rx_trig_d;
    end
  end

  rx_timeout_fsm u_rx_timeout_fsm (
    .clk_i         (m_clk),
    .rst_i         (reset),
    .fifoen_i      (fifoen_q),
    .rxclr_i       (rxclr_q),
    .rx_nonempty_i (rx_count != '0),
    .rx_push_i     (rx_push),
    .rx_pop_i      (rx_pop),
    .char_tick_i   (char_tick),
    .rx_timeout_o  (rx_timeout)
  );

  assign FIFOEN  = fifoen_q;
  assign RXCLR   = rxclr_q;
  assign TXCLR   = txclr_q;
  assign DMAMODE = dmamode_q;
  assign RXFIFTL = rxfiftl_q;
  assign rx_trig = rx_trig_q;

endmodule

// File: tb/tb_fifo_ctrl_unit.sv
// Directed bench for fifo_ctrl_unit (DEPTH=16): register decode, clear
// pulses, thresholds, trigger flag, character timeout and reset abort.
module tb_fifo_ctrl_unit;

  logic       m_clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [4:0] rx_count;
  logic       rx_push, rx_pop, char_tick;
  logic       FIFOEN, RXCLR, TXCLR, DMAMODE, rx_trig, rx_timeout;
  logic [1:0] RXFIFTL;
  logic [4:0] rx_threshold;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_ctrl_unit dut (
    .m_clk        (m_clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .address      (address),
    .data_in      (data_in),
    .rx_count     (rx_count),
    .rx_push      (rx_push),
    .rx_pop       (rx_pop),
    .char_tick    (char_tick),
    .FIFOEN       (FIFOEN),
    .RXCLR        (RXCLR),
    .TXCLR        (TXCLR),
    .DMAMODE      (DMAMODE),
    .RXFIFTL      (RXFIFTL),
    .rx_threshold (rx_threshold),
    .rx_trig      (rx_trig),
    .rx_timeout   (rx_timeout)
  );

  always #5 m_clk = ~m_clk;

  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  task automatic fcr_write(input logic [7:0] addr, input logic [7:0] data);
    wr_en = 1'b1; address = addr; data_in = data;
    step();
    wr_en = 1'b0; address = 8'h00; data_in = 8'h00;
  endtask

  task automatic tick_once();
    char_tick = 1'b1;
    step();
    char_tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 0; address = 0; data_in = 0;
    rx_count = 0; rx_push = 0; rx_pop = 0; char_tick = 0;
    repeat (2) @(posedge m_clk);
    #1;
    n_cmp++;
    if ({FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL, rx_trig, rx_timeout} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 00000000",
               {FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL, rx_trig, rx_timeout});
    end
    n_cmp++;
    if (rx_threshold !== 5'd1) begin
      n_bad++; $display("FAIL reset_threshold: got %0d want 1", rx_threshold);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_enable_write();
    fcr_write(8'h08, 8'hC7);
    n_cmp++;
    if ({FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL} !== 6'b111011) begin
      n_bad++; $display("FAIL c7_write: got %b want 111011", {FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL});
    end
    n_cmp++;
    if (rx_threshold !== 5'd14) begin
      n_bad++; $display("FAIL c7_threshold: got %0d want 14", rx_threshold);
    end
    step();
    n_cmp++;
    if ({RXCLR, TXCLR, FIFOEN} !== 3'b001) begin
      n_bad++; $display("FAIL c7_pulse_end: got %b want 001", {RXCLR, TXCLR, FIFOEN});
    end
  endtask

  task automatic test_disable_write();
    fcr_write(8'h08, 8'h40);
    n_cmp++;
    if ({FIFOEN, RXCLR, TXCLR, RXFIFTL} !== 5'b01111) begin
      n_bad++; $display("FAIL disable_write: got %b want 01111", {FIFOEN, RXCLR, TXCLR, RXFIFTL});
    end
    step();
    n_cmp++;
    if ({RXCLR, TXCLR} !== 2'b00) begin
      n_bad++; $display("FAIL disable_pulse_end: got %b want 00", {RXCLR, TXCLR});
    end
  endtask

  task automatic test_wrong_address();
    fcr_write(8'h09, 8'hC7);
    n_cmp++;
    if ({FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL} !== 6'b000011) begin
      n_bad++; $display("FAIL wrong_addr: got %b want 000011", {FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL});
    end
  endtask

  task automatic test_field_hold();
    // Enable with DMA mode and code 00, then disable: DMA and code must hold.
    fcr_write(8'h08, 8'h09);
    n_cmp++;
    if ({FIFOEN, DMAMODE, RXFIFTL, RXCLR, TXCLR} !== 6'b110011) begin
      n_bad++; $display("FAIL dma_enable: got %b want 110011", {FIFOEN, DMAMODE, RXFIFTL, RXCLR, TXCLR});
    end
    fcr_write(8'h08, 8'hF0);
    n_cmp++;
    if ({FIFOEN, DMAMODE, RXFIFTL} !== 4'b0100) begin
      n_bad++; $display("FAIL field_hold: got %b want 0100", {FIFOEN, DMAMODE, RXFIFTL});
    end
    step();
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; address = 8'h08; data_in = 8'h06;
    step();
    n_cmp++;
    if ({RXCLR, TXCLR} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_first: got %b want 11", {RXCLR, TXCLR});
    end
    data_in = 8'h02;
    step();
    n_cmp++;
    if ({RXCLR, TXCLR} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_second: got %b want 10", {RXCLR, TXCLR});
    end
    wr_en = 1'b0; data_in = 8'h00;
    step();
    n_cmp++;
    if ({RXCLR, TXCLR, FIFOEN} !== 3'b000) begin
      n_bad++; $display("FAIL b2b_end: got %b want 000", {RXCLR, TXCLR, FIFOEN});
    end
  endtask

  task automatic test_thresholds();
    logic [7:0] wdata [4] = '{8'h01, 8'h41, 8'h81, 8'hC1};
    logic [4:0] want  [4] = '{5'd1, 5'd4, 5'd8, 5'd14};
    for (int i = 0; i < 4; i++) begin
      fcr_write(8'h08, wdata[i]);
      n_cmp++;
      if (rx_threshold !== want[i] || (i > 0 && RXCLR !== 1'b0)) begin
        n_bad++;
        $display("FAIL threshold_%0d: got thr=%0d rxclr=%b want thr=%0d rxclr=%b",
                 i, rx_threshold, RXCLR, want[i], (i == 0));
      end
    end
    step();
  endtask

  task automatic test_trigger();
    fcr_write(8'h08, 8'h81);
    rx_count = 5'd7;
    step();
    n_cmp++;
    if (rx_trig !== 1'b0) begin n_bad++; $display("FAIL trig_at_7: got %b want 0", rx_trig); end
    rx_count = 5'd8;
    #1;
    n_cmp++;
    if (rx_trig !== 1'b0) begin n_bad++; $display("FAIL trig_latency_rise: got %b want 0", rx_trig); end
    step();
    n_cmp++;
    if (rx_trig !== 1'b1) begin n_bad++; $display("FAIL trig_at_8: got %b want 1", rx_trig); end
    rx_count = 5'd7;
    #1;
    n_cmp++;
    if (rx_trig !== 1'b1) begin n_bad++; $display("FAIL trig_latency_fall: got %b want 1", rx_trig); end
    step();
    n_cmp++;
    if (rx_trig !== 1'b0) begin n_bad++; $display("FAIL trig_back_7: got %b want 0", rx_trig); end
    rx_count = 5'd8;
    step();
    fcr_write(8'h08, 8'h83);
    n_cmp++;
    if ({RXCLR, rx_trig} !== 2'b10) begin
      n_bad++; $display("FAIL trig_during_clear: got %b want 10", {RXCLR, rx_trig});
    end
    step();
    n_cmp++;
    if (rx_trig !== 1'b1) begin n_bad++; $display("FAIL trig_after_clear: got %b want 1", rx_trig); end
    rx_count = 5'd0;
    step();
  endtask

  task automatic test_timeout();
    rx_count = 5'd3;
    step();
    for (int i = 0; i < 3; i++) tick_once();
    n_cmp++;
    if (rx_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_3_ticks: got %b want 0", rx_timeout); end
    tick_once();
    n_cmp++;
    if (rx_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_4_ticks: got %b want 1", rx_timeout); end
    step();
    n_cmp++;
    if (rx_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_hold: got %b want 1", rx_timeout); end
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
    n_cmp++;
    if (rx_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_pop: got %b want 0", rx_timeout); end
    tick_once();
    tick_once();
    rx_push = 1'b1;
    tick_once();
    rx_push = 1'b0;
    for (int i = 0; i < 3; i++) tick_once();
    n_cmp++;
    if (rx_timeout !== 1'b0) begin n_bad++; $display("FAIL push_restart: got %b want 0", rx_timeout); end
    tick_once();
    n_cmp++;
    if (rx_timeout !== 1'b1) begin n_bad++; $display("FAIL push_restart_expire: got %b want 1", rx_timeout); end
    rx_count = 5'd0;
    step();
    n_cmp++;
    if (rx_timeout !== 1'b0) begin n_bad++; $display("FAIL empty_forces_idle: got %b want 0", rx_timeout); end
    rx_count = 5'd3;
    step();
    for (int i = 0; i < 4; i++) tick_once();
    n_cmp++;
    if (rx_timeout !== 1'b1) begin n_bad++; $display("FAIL rearm_expire: got %b want 1", rx_timeout); end
  endtask

  task automatic test_reset_abort();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL, rx_trig, rx_timeout} !== 8'h00) begin
      n_bad++; $display("FAIL reset_in_expired: got %b want 00000000",
                        {FIFOEN, RXCLR, TXCLR, DMAMODE, RXFIFTL, rx_trig, rx_timeout});
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({rx_timeout, RXCLR, FIFOEN} !== 3'b000) begin
      n_bad++; $display("FAIL after_reset_expired: got %b want 000", {rx_timeout, RXCLR, FIFOEN});
    end
    fcr_write(8'h08, 8'h07);
    n_cmp++;
    if (RXCLR !== 1'b1) begin n_bad++; $display("FAIL pre_abort_pulse: got %b want 1", RXCLR); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({RXCLR, TXCLR, FIFOEN} !== 3'b000) begin
      n_bad++; $display("FAIL reset_mid_pulse: got %b want 000", {RXCLR, TXCLR, FIFOEN});
    end
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if ({RXCLR, TXCLR, FIFOEN, rx_timeout} !== 4'b0000) begin
      n_bad++; $display("FAIL no_pulse_after_release: got %b want 0000", {RXCLR, TXCLR, FIFOEN, rx_timeout});
    end
  endtask

  initial begin
    test_reset();
    test_enable_write();
    test_disable_write();
    test_wrong_address();
    test_field_hold();
    test_back_to_back();
    test_thresholds();
    test_trigger();
    test_timeout();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
